// File: rtl/output_display_driver.sv
// Resynchronises and debounces the CPU result, keeps a 4-deep history of distinct
// committed values and scans them onto a 4-digit active-low seven-segment display.
module output_display_driver #(
   parameter int unsigned DATA_WIDTH   = 4,
   parameter int unsigned STABLE_CNT   = 4,
   parameter int unsigned REFRESH_BITS = 17
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  hold,
   input  logic                  clear,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [3:0]            an,
   output logic [7:0]            change_count
);

   localparam int unsigned CNT_W = $clog2(STABLE_CNT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

   logic [DATA_WIDTH-1:0]   s1, s2, cand;
   logic [CNT_W-1:0]        cnt;
   logic [DATA_WIDTH-1:0]   d [4];
   logic [3:0]              v;
   logic                    commit;
   logic [REFRESH_BITS-1:0] refresh_cnt;
   logic [1:0]              sel;
   logic [6:0]              seg_nxt;
   logic                    dp_nxt;
   logic [3:0]              an_nxt;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1   <= '0;
         s2   <= '0;
         cand <= '0;
         cnt  <= '0;
      end else begin
         s1 <= data_in;
         s2 <= s1;
         if (s2 != cand) begin
            cand <= s2;
            cnt  <= '0;
         end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // cnt stays saturated through hold/clear, so a stable candidate commits on release
   assign commit = (cnt == CNT_MAX) && !hold && !clear && (!v[0] || (cand != d[0]));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 4; i++) d[i] <= '0;
         v            <= '0;
         change_count <= '0;
      end else if (clear) begin
         v            <= '0;
         change_count <= '0;
      end else if (commit) begin
         d[3]         <= d[2];
         d[2]         <= d[1];
         d[1]         <= d[0];
         d[0]         <= cand;
         v            <= {v[2:0], 1'b1};
         change_count <= change_count + 8'd1;
      end
   end

   assign sel = refresh_cnt[REFRESH_BITS-1 -: 2];

   always_comb begin
      an_nxt      = 4'b1111;
      an_nxt[sel] = 1'b0;
      seg_nxt     = v[sel] ? hex_to_seg(d[sel]) : 7'h7F;
      dp_nxt      = !((sel == 2'd0) && v[0]);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         refresh_cnt <= '0;
         an          <= 4'b1111;
         seg         <= 7'h7F;
         dp          <= 1'b1;
      end else begin
         refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
         an          <= an_nxt;
         seg         <= seg_nxt;
         dp          <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_output_display_driver.sv
// Directed bench for output_display_driver: a small history model pushes expected
// values to a scoreboard queue, observations pop and compare them.
module tb_output_display_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] data_in;
   logic       hold;
   logic       clear;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;
   logic [7:0] change_count;

   always #5 clk = ~clk;

   output_display_driver #(
      .DATA_WIDTH  (4),
      .STABLE_CNT  (4),
      .REFRESH_BITS(4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .data_in     (data_in),
      .hold        (hold),
      .clear       (clear),
      .seg         (seg),
      .dp          (dp),
      .an          (an),
      .change_count(change_count)
   );

   typedef struct {
      string      tag;
      logic [7:0] exp;
   } exp_t;

   exp_t        sb [$];
   int unsigned checks   = 0;
   int unsigned failures = 0;

   logic [3:0] m_d [4];
   logic [3:0] m_v;
   logic [7:0] m_cc;
   logic [6:0] hex_lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input string tag, input logic [7:0] e);
      exp_t x;
      x.tag = tag;
      x.exp = e;
      sb.push_back(x);
   endtask

   task automatic pop_check(input logic [7:0] obs);
      exp_t x;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_empty observed=%h expected=<none>", obs);
      end else begin
         x = sb.pop_front();
         assert (obs === x.exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
         end
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_d[i] = '0;
      m_v  = '0;
      m_cc = '0;
   endtask

   task automatic m_commit(input logic [3:0] val);
      if (!m_v[0] || (val != m_d[0])) begin
         m_d[3] = m_d[2];
         m_d[2] = m_d[1];
         m_d[1] = m_d[0];
         m_d[0] = val;
         m_v    = {m_v[2:0], 1'b1};
         m_cc   = m_cc + 8'd1;
      end
   endtask

   task automatic check_cc(input string tag);
      push(tag, m_cc);
      pop_check(change_count);
   endtask

   task automatic check_reset_outputs(input string tag);
      push({tag, "_an"}, 8'h0F);
      pop_check({4'b0, an});
      push({tag, "_seg"}, 8'h7F);
      pop_check({1'b0, seg});
      push({tag, "_dp"}, 8'h01);
      pop_check({7'b0, dp});
      push({tag, "_cc"}, 8'h00);
      pop_check(change_count);
   endtask

   // One full refresh period; each digit's last displayed value is compared to the model.
   task automatic scan_check(input string tag);
      logic [6:0]  rs [4];
      logic        rd [4];
      int unsigned bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         rs[i] = 'x;
         rd[i] = 1'bx;
      end
      for (int k = 0; k < 16; k++) begin
         case (an)
            4'b1110: begin rs[0] = seg; rd[0] = dp; end
            4'b1101: begin rs[1] = seg; rd[1] = dp; end
            4'b1011: begin rs[2] = seg; rd[2] = dp; end
            4'b0111: begin rs[3] = seg; rd[3] = dp; end
            default: bad++;
         endcase
         tick(1);
      end
      push($sformatf("%s_an_onehot", tag), 8'h00);
      pop_check(8'(bad));
      for (int i = 0; i < 4; i++) begin
         push($sformatf("%s_seg_d%0d", tag, i), m_v[i] ? {1'b0, hex_lut[m_d[i]]} : 8'h7F);
         pop_check({1'b0, rs[i]});
         push($sformatf("%s_dp_d%0d", tag, i), ((i == 0) && m_v[0]) ? 8'h00 : 8'h01);
         pop_check({7'b0, rd[i]});
      end
   endtask

   initial begin
      logic [3:0] vals [3] = '{4'h3, 4'h5, 4'hA};
      logic [3:0] val;

      reset   = 1'b0;
      data_in = 4'h0;
      hold    = 1'b0;
      clear   = 1'b0;
      m_reset();

      tick(3);
      check_reset_outputs("rst");

      reset = 1'b1;
      m_commit(4'h0);
      tick(7);
      check_cc("cc_first");
      scan_check("scan_first");

      for (int i = 0; i < 3; i++) begin
         data_in = vals[i];
         m_commit(vals[i]);
         tick(20);
      end
      check_cc("cc_three");
      scan_check("scan_hist");

      data_in = 4'h5;
      m_commit(4'h5);
      tick(20);
      check_cc("cc_five");
      data_in = 4'h9;
      tick(2);
      data_in = 4'h5;
      tick(20);
      check_cc("cc_glitch");
      scan_check("scan_glitch");

      data_in = 4'h7;
      m_commit(4'h7);
      tick(100);
      check_cc("cc_long_hold");

      hold    = 1'b1;
      data_in = 4'hC;
      tick(20);
      check_cc("cc_hold");
      hold = 1'b0;
      m_commit(4'hC);
      tick(1);
      check_cc("cc_hold_release");
      scan_check("scan_hold");

      data_in = 4'hE;
      tick(6);
      check_cc("cc_pre_clear");
      clear = 1'b1;
      m_v  = '0;
      m_cc = '0;
      tick(1);
      check_cc("cc_clear");
      scan_check("scan_clear");
      clear = 1'b0;
      m_commit(4'hE);
      tick(1);
      check_cc("cc_after_clear");
      scan_check("scan_after_clear");

      data_in = 4'h2;
      tick(3);
      reset = 1'b0;
      m_reset();
      #1;
      check_reset_outputs("rst_mid");
      tick(2);
      reset = 1'b1;
      tick(6);
      check_cc("cc_rst_early");
      m_commit(4'h2);
      tick(1);
      check_cc("cc_rst_latency");

      for (int i = 0; i < 255; i++) begin
         val     = (i % 2 == 1) ? 4'h2 : 4'h1;
         data_in = val;
         m_commit(val);
         tick(8);
      end
      check_cc("cc_wrap");
      data_in = 4'h1;
      m_commit(4'h1);
      tick(8);
      check_cc("cc_post_wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
